// File: rtl/hazard_stall_controller_pkg.sv
// -----------------------------------------------------------------------------
// core_pipe_pkg
// Definitions shared by the 5-stage RV32 pipeline control blocks:
//   - pipe_state_e    : sequencer state (RUN / MD_WAIT / MEM_WAIT)
//   - REG_ADDR_W, X0  : register-file address width and the hard-wired zero reg
//   - CNT_W_DEFAULT   : default width of the saturating status counters
//   - reg_match()     : operand/destination dependence test with x0 filtering
// -----------------------------------------------------------------------------
package core_pipe_pkg;

    localparam int REG_ADDR_W    = 5;
    localparam int CNT_W_DEFAULT = 16;

    localparam logic [REG_ADDR_W-1:0] X0 = '0;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MD_WAIT  = 2'd1,
        ST_MEM_WAIT = 2'd2
    } pipe_state_e;

    // True when an operand that is actually read depends on rd.
    // Writes to x0 are discarded by the register file, so they never matter.
    function automatic logic reg_match(
        input logic                  use_rs,
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] rd
    );
        return use_rs && (rd != X0) && (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_stall_controller_if.sv
// -----------------------------------------------------------------------------
// hazard_stall_controller_if
// Bundle between the pipeline datapath (master) and the hazard/stall
// sequencer (slave).
//   master drives : ID operand info, EX load/redirect/mul-div info,
//                   mul/div completion, MEM request and data-memory ready
//   slave drives  : per-stage write enables, bubble/flush controls,
//                   stall/flush counters, mul/div timeout flag
// -----------------------------------------------------------------------------
interface hazard_stall_controller_if #(
    parameter int CNT_W = core_pipe_pkg::CNT_W_DEFAULT
);
    import core_pipe_pkg::*;

    // datapath -> controller
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic                  ex_memread;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_redirect;
    logic                  ex_muldiv_start;
    logic                  muldiv_done;
    logic                  mem_req;
    logic                  dmem_ready;

    // controller -> datapath
    logic                  pc_we;
    logic                  ifid_we;
    logic                  ifid_flush;
    logic                  idex_we;
    logic                  idex_bubble;
    logic                  exmem_we;
    logic                  exmem_bubble;
    logic                  memwb_we;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;
    logic                  err_md_timeout;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_memread, ex_rd, ex_redirect, ex_muldiv_start,
        output muldiv_done, mem_req, dmem_ready,
        input  pc_we, ifid_we, ifid_flush, idex_we, idex_bubble,
        input  exmem_we, exmem_bubble, memwb_we,
        input  stall_cnt, flush_cnt, err_md_timeout
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_memread, ex_rd, ex_redirect, ex_muldiv_start,
        input  muldiv_done, mem_req, dmem_ready,
        output pc_we, ifid_we, ifid_flush, idex_we, idex_bubble,
        output exmem_we, exmem_bubble, memwb_we,
        output stall_cnt, flush_cnt, err_md_timeout
    );

endinterface

// File: rtl/hazard_stall_controller_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low clear
//   clr_i   : synchronous clear (wins over inc_i)
//   inc_i   : increment this cycle
//   cnt_o   : current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_stall_controller.sv
// -----------------------------------------------------------------------------
// hazard_stall_controller
// Pipeline sequencer for the 5-stage RV32 core. Covers the hazards that
// forwarding cannot: load-use, EX redirects, multi-cycle mul/div occupancy and
// data-memory wait states. Only the state, the counters and the timeout flag
// are registered; every stage control is combinational from state + inputs.
//   clk      : core clock, rising edge
//   rst_n    : asynchronous active-low reset
//   pipe_if  : hazard_stall_controller_if.slave (inputs from the datapath,
//              stage enables/bubbles/flush and status back to it)
// Priority, highest first: memory stall > mul/div wait > redirect > load-use.
// -----------------------------------------------------------------------------
module hazard_stall_controller
    import core_pipe_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,             // legal range 2..65535
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    hazard_stall_controller_if.slave  pipe_if
);

    localparam int MD_CNT_W = 16;
    // The wait counter reads MD_LAST during the MD_TIMEOUT-th wait cycle;
    // the flag is set on the edge that takes it to MD_TIMEOUT.
    localparam logic [MD_CNT_W-1:0] MD_LAST = 16'(MD_TIMEOUT - 1);

    pipe_state_e         state_q, state_d;
    logic                err_q, err_d;

    logic                mem_stall;
    logic                load_use;
    logic                md_entry;
    logic                md_inc;
    logic                flush_inc;
    logic [MD_CNT_W-1:0] md_wait_cnt;

    logic                pc_we, ifid_we, ifid_flush, idex_we, idex_bubble;
    logic                exmem_we, exmem_bubble, memwb_we;

    assign mem_stall = pipe_if.mem_req && !pipe_if.dmem_ready;
    assign load_use  = pipe_if.ex_memread &&
                       (reg_match(pipe_if.id_use_rs1, pipe_if.id_rs1, pipe_if.ex_rd) ||
                        reg_match(pipe_if.id_use_rs2, pipe_if.id_rs2, pipe_if.ex_rd));

    always_comb begin
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        ifid_flush   = 1'b0;
        idex_we      = 1'b1;
        idex_bubble  = 1'b0;
        exmem_we     = 1'b1;
        exmem_bubble = 1'b0;
        memwb_we     = 1'b1;
        flush_inc    = 1'b0;
        state_d      = state_q;

        if (!rst_n) begin
            // Hold fetch and feed NOPs into EX while the core is in reset.
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
            state_d     = ST_RUN;
        end else if (mem_stall) begin
            // Freeze the whole pipe. Anything pending in EX (redirect,
            // load-use) stays put and is acted on once memory completes.
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            idex_we  = 1'b0;
            exmem_we = 1'b0;
            memwb_we = 1'b0;
            if (state_q != ST_MD_WAIT) begin
                state_d = ST_MEM_WAIT;
            end else if (pipe_if.muldiv_done) begin
                // The mul/div unit holds its result until EX advances, so the
                // wait can finish even while memory is frozen.
                state_d = ST_RUN;
            end
        end else if (state_q == ST_MD_WAIT) begin
            if (pipe_if.muldiv_done) begin
                state_d = ST_RUN;
            end else begin
                pc_we        = 1'b0;
                ifid_we      = 1'b0;
                idex_we      = 1'b0;
                exmem_bubble = 1'b1;
            end
        end else begin
            // RUN, or MEM_WAIT in the cycle memory completes.
            state_d = ST_RUN;
            if (pipe_if.ex_muldiv_start && !pipe_if.muldiv_done) begin
                // The op must stay in EX from its very first cycle.
                pc_we        = 1'b0;
                ifid_we      = 1'b0;
                idex_we      = 1'b0;
                exmem_bubble = 1'b1;
                state_d      = ST_MD_WAIT;
            end else if (pipe_if.ex_redirect) begin
                // A redirect kills the ID instruction, so any load-use
                // dependence it had is moot.
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                flush_inc   = 1'b1;
            end else if (load_use) begin
                // The load leaves EX next cycle, so one bubble suffices.
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_bubble = 1'b1;
            end
        end
    end

    assign md_entry = (state_q != ST_MD_WAIT) && (state_d == ST_MD_WAIT);
    assign md_inc   = (state_q == ST_MD_WAIT);
    assign err_d    = err_q || (md_inc && (md_wait_cnt == MD_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (1'b0),
        .inc_i (!pc_we),
        .cnt_o (pipe_if.stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (1'b0),
        .inc_i (flush_inc),
        .cnt_o (pipe_if.flush_cnt)
    );

    sat_counter #(.WIDTH(MD_CNT_W)) u_md_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (md_entry),
        .inc_i (md_inc),
        .cnt_o (md_wait_cnt)
    );

    assign pipe_if.pc_we          = pc_we;
    assign pipe_if.ifid_we        = ifid_we;
    assign pipe_if.ifid_flush     = ifid_flush;
    assign pipe_if.idex_we        = idex_we;
    assign pipe_if.idex_bubble    = idex_bubble;
    assign pipe_if.exmem_we       = exmem_we;
    assign pipe_if.exmem_bubble   = exmem_bubble;
    assign pipe_if.memwb_we       = memwb_we;
    assign pipe_if.err_md_timeout = err_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
module tb_hazard_stall_controller;

    // Control vector order:
    // {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, exmem_bubble, memwb_we}
    localparam logic [7:0] CTL_RUN   = 8'b1101_0101;
    localparam logic [7:0] CTL_RST   = 8'b0001_1101;
    localparam logic [7:0] CTL_LU    = 8'b0001_1101;
    localparam logic [7:0] CTL_FLUSH = 8'b1111_1101;
    localparam logic [7:0] CTL_MD    = 8'b0000_0111;
    localparam logic [7:0] CTL_MEM   = 8'b0000_0000;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    // Main instance: default parameters. Small instance: MD_TIMEOUT=4, CNT_W=4,
    // driven with the same stimulus.
    hazard_stall_controller_if #(.CNT_W(16)) m_if ();
    hazard_stall_controller_if #(.CNT_W(4))  s_if ();

    assign s_if.id_rs1          = m_if.id_rs1;
    assign s_if.id_rs2          = m_if.id_rs2;
    assign s_if.id_use_rs1      = m_if.id_use_rs1;
    assign s_if.id_use_rs2      = m_if.id_use_rs2;
    assign s_if.ex_memread      = m_if.ex_memread;
    assign s_if.ex_rd           = m_if.ex_rd;
    assign s_if.ex_redirect     = m_if.ex_redirect;
    assign s_if.ex_muldiv_start = m_if.ex_muldiv_start;
    assign s_if.muldiv_done     = m_if.muldiv_done;
    assign s_if.mem_req         = m_if.mem_req;
    assign s_if.dmem_ready      = m_if.dmem_ready;

    hazard_stall_controller #(.MD_TIMEOUT(64), .CNT_W(16)) u_dut_m (
        .clk     (clk),
        .rst_n   (rst_n),
        .pipe_if (m_if.slave)
    );

    hazard_stall_controller #(.MD_TIMEOUT(4), .CNT_W(4)) u_dut_s (
        .clk     (clk),
        .rst_n   (rst_n),
        .pipe_if (s_if.slave)
    );

    logic [7:0] ctl_m, ctl_s;
    assign ctl_m = {m_if.pc_we, m_if.ifid_we, m_if.ifid_flush, m_if.idex_we,
                    m_if.idex_bubble, m_if.exmem_we, m_if.exmem_bubble, m_if.memwb_we};
    assign ctl_s = {s_if.pc_we, s_if.ifid_we, s_if.ifid_flush, s_if.idex_we,
                    s_if.idex_bubble, s_if.exmem_we, s_if.exmem_bubble, s_if.memwb_we};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        m_if.id_rs1          = '0;
        m_if.id_rs2          = '0;
        m_if.id_use_rs1      = 1'b0;
        m_if.id_use_rs2      = 1'b0;
        m_if.ex_memread      = 1'b0;
        m_if.ex_rd           = '0;
        m_if.ex_redirect     = 1'b0;
        m_if.ex_muldiv_start = 1'b0;
        m_if.muldiv_done     = 1'b0;
        m_if.mem_req         = 1'b0;
        m_if.dmem_ready      = 1'b0;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // at the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        clr_in();

        // Reset state
        #2;
        chk("rst_ctl_m",   32'(ctl_m), 32'(CTL_RST));
        chk("rst_ctl_s",   32'(ctl_s), 32'(CTL_RST));
        chk("rst_stall_m", 32'(m_if.stall_cnt), 32'd0);
        chk("rst_flush_m", 32'(m_if.flush_cnt), 32'd0);
        chk("rst_err_s",   32'(s_if.err_md_timeout), 32'd0);
        step();
        rst_n = 1'b1;

        // Idle
        @(negedge clk);
        chk("idle_ctl", 32'(ctl_m), 32'(CTL_RUN));
        step();

        // Load-use on rs2: exactly one bubble
        m_if.ex_memread = 1'b1; m_if.ex_rd = 5'd5; m_if.id_rs2 = 5'd5; m_if.id_use_rs2 = 1'b1;
        @(negedge clk);
        chk("lu_rs2_ctl_m", 32'(ctl_m), 32'(CTL_LU));
        chk("lu_rs2_ctl_s", 32'(ctl_s), 32'(CTL_LU));
        step();
        clr_in();
        @(negedge clk);
        chk("lu_after_ctl", 32'(ctl_m), 32'(CTL_RUN));
        chk("lu_stall_m",   32'(m_if.stall_cnt), 32'd1);
        chk("lu_stall_s",   32'(s_if.stall_cnt), 32'd1);
        step();

        // x0 destination never stalls
        m_if.ex_memread = 1'b1; m_if.ex_rd = 5'd0; m_if.id_rs2 = 5'd0; m_if.id_use_rs2 = 1'b1;
        @(negedge clk);
        chk("x0_ctl", 32'(ctl_m), 32'(CTL_RUN));
        step();
        clr_in();

        // Matching rs1 that is not read
        m_if.ex_memread = 1'b1; m_if.ex_rd = 5'd5; m_if.id_rs1 = 5'd5; m_if.id_use_rs1 = 1'b0;
        @(negedge clk);
        chk("unused_rs1_ctl", 32'(ctl_m), 32'(CTL_RUN));
        step();

        // Same, but rs1 is read
        m_if.id_use_rs1 = 1'b1;
        @(negedge clk);
        chk("lu_rs1_ctl", 32'(ctl_m), 32'(CTL_LU));
        step();
        clr_in();

        // Redirect together with load-use: flush wins, no stall
        m_if.ex_redirect = 1'b1; m_if.ex_memread = 1'b1; m_if.ex_rd = 5'd5;
        m_if.id_rs1 = 5'd5; m_if.id_use_rs1 = 1'b1;
        @(negedge clk);
        chk("redir_lu_ctl", 32'(ctl_m), 32'(CTL_FLUSH));
        step();
        clr_in();
        @(negedge clk);
        chk("redir_flush_m", 32'(m_if.flush_cnt), 32'd1);
        chk("redir_flush_s", 32'(s_if.flush_cnt), 32'd1);
        chk("redir_stall_m", 32'(m_if.stall_cnt), 32'd2);
        step();

        // Mul/div: start pulse, done 10 cycles later
        m_if.ex_muldiv_start = 1'b1;
        @(negedge clk);
        chk("md_start_ctl", 32'(ctl_m), 32'(CTL_MD));
        step();
        m_if.ex_muldiv_start = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            chk($sformatf("md_wait%0d_ctl", i), 32'(ctl_m), 32'(CTL_MD));
            if (i == 4) chk("md_err_s_before", 32'(s_if.err_md_timeout), 32'd0);
            if (i == 5) chk("md_err_s_rise",   32'(s_if.err_md_timeout), 32'd1);
            step();
        end
        m_if.muldiv_done = 1'b1;
        @(negedge clk);
        chk("md_done_ctl", 32'(ctl_m), 32'(CTL_RUN));
        step();
        m_if.muldiv_done = 1'b0;
        @(negedge clk);
        chk("md_after_ctl", 32'(ctl_m), 32'(CTL_RUN));
        chk("md_stall_m",   32'(m_if.stall_cnt), 32'd12);
        chk("md_stall_s",   32'(s_if.stall_cnt), 32'd12);
        chk("md_err_s_hold", 32'(s_if.err_md_timeout), 32'd1);
        chk("md_err_m",     32'(m_if.err_md_timeout), 32'd0);
        step();

        // Start and done together: no wait state
        m_if.ex_muldiv_start = 1'b1; m_if.muldiv_done = 1'b1;
        @(negedge clk);
        chk("md_same_ctl", 32'(ctl_m), 32'(CTL_RUN));
        step();
        clr_in();
        @(negedge clk);
        chk("md_same_next_ctl", 32'(ctl_m), 32'(CTL_RUN));
        chk("md_same_stall",    32'(m_if.stall_cnt), 32'd12);
        step();

        // Memory stall holding a redirect for 3 cycles
        m_if.mem_req = 1'b1; m_if.dmem_ready = 1'b0; m_if.ex_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("mem%0d_ctl", i), 32'(ctl_m), 32'(CTL_MEM));
            step();
        end
        m_if.dmem_ready = 1'b1;
        @(negedge clk);
        chk("mem_release_ctl", 32'(ctl_m), 32'(CTL_FLUSH));
        step();
        clr_in();
        @(negedge clk);
        chk("mem_after_ctl", 32'(ctl_m), 32'(CTL_RUN));
        chk("mem_flush_m",   32'(m_if.flush_cnt), 32'd2);
        chk("mem_stall_m",   32'(m_if.stall_cnt), 32'd15);
        chk("mem_stall_s",   32'(s_if.stall_cnt), 32'd15);
        step();

        // Five more stall cycles: 20 total, small counter saturates at 15
        m_if.mem_req = 1'b1; m_if.dmem_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        clr_in();
        @(negedge clk);
        chk("sat_stall_m", 32'(m_if.stall_cnt), 32'd20);
        chk("sat_stall_s", 32'(s_if.stall_cnt), 32'd15);
        step();

        // Reset asserted while in MD_WAIT
        m_if.ex_muldiv_start = 1'b1;
        step();
        m_if.ex_muldiv_start = 1'b0;
        @(negedge clk);
        chk("rstmd_wait_ctl", 32'(ctl_m), 32'(CTL_MD));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmd_ctl_m",   32'(ctl_m), 32'(CTL_RST));
        chk("rstmd_stall_m", 32'(m_if.stall_cnt), 32'd0);
        chk("rstmd_flush_m", 32'(m_if.flush_cnt), 32'd0);
        chk("rstmd_err_s",   32'(s_if.err_md_timeout), 32'd0);
        #1;
        rst_n = 1'b1;
        step();
        @(negedge clk);
        chk("rstmd_run_ctl", 32'(ctl_m), 32'(CTL_RUN));
        chk("rstmd_run_stall", 32'(m_if.stall_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
